maze_path_tracker: RTL and testbench
====================================

Name: maze_path_tracker

Overview:
- Sits directly downstream of the maze solver system and consumes its 2-bit Move stream.
- Buffers the solved path in a FIFO, then replays it one step at a time to a consumer (display or motor driver) under a valid/ready handshake.
- Tracks the absolute X/Y position during replay.
- Flags a solver failure, path overflow, or a step that leaves the grid.

Parameters:
- DEPTH, 256, FIFO capacity in moves (one full 16x16 maze).
- ADDR_X, 4, width of the X coordinate.
- ADDR_Y, 4, width of the Y coordinate.
- START_X, 0, X coordinate loaded on start.
- START_Y, 0, Y coordinate loaded on start.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: clear the FIFO, load START_X/START_Y, enter CAPTURE.
- move_valid  in  1  Move is valid this cycle.
- move  in  2  solver Move code.
- path_done  in  1  solver Done (level).
- path_fail  in  1  solver Fail (level).
- step_ready  in  1  consumer accepts the presented step.
- step_valid  out  1  step_move is valid.
- step_move  out  2  head-of-FIFO move.
- pos_x  out  ADDR_X  current X.
- pos_y  out  ADDR_Y  current Y.
- path_len  out  $clog2(DEPTH)+1  number of moves captured.
- busy  out  1  state is CAPTURE or REPLAY.
- tracker_done  out  1  replay complete.
- error  out  1  state is ERROR.
- err_code  out  2  00 none, 01 solver fail, 10 overflow, 11 out of bounds.

Behaviour:
- Move encoding: 00 = up (y-1), 01 = right (x+1), 10 = left (x-1), 11 = down (y+1).
- Reset (async, rst=1):
  - State goes to IDLE and the FIFO empties.
  - pos_x=START_X, pos_y=START_Y, path_len=0.
  - All flags are 0; err_code=00; step_move=00.
  - Reset during any state aborts immediately.
- IDLE:
  - Inputs other than start are ignored.
  - start moves to CAPTURE.
- CAPTURE:
  - move_valid pushes move into the FIFO and increments path_len, registered with 1-cycle latency.
  - path_fail=1 moves to ERROR with err_code=01. Fail has priority over path_done in the same cycle.
  - path_done=1 moves to REPLAY. A move_valid in that same cycle is still captured.
  - move_valid while the FIFO is full: the write is dropped and the state goes to ERROR with err_code=10.
  - path_done with an empty FIFO goes straight to DONE.
- REPLAY:
  - step_valid = FIFO not empty; step_move = FIFO head, combinational from the FIFO read port.
  - On step_valid & step_ready:
    - Pop the FIFO.
    - Update pos_x/pos_y on the same clock edge.
    - The next entry is presented the following cycle, giving 1 step/cycle throughput.
  - If the accepted step would move x below 0 or above 2^ADDR_X-1 (same for y):
    - Position holds; no wrap-around.
    - The entry is popped; state goes to ERROR with err_code=11.
  - step_valid holds with stable step_move until accepted.
  - FIFO empty after the last pop moves to DONE.
  - move_valid in REPLAY is ignored.
- DONE:
  - tracker_done=1; pos holds the final coordinates; step_valid=0.
- ERROR:
  - error=1; step_valid=0; pos and err_code hold.
- start:
  - In DONE or ERROR: restarts (clear FIFO, path_len=0, flags cleared, position reloaded, enter CAPTURE).
  - In CAPTURE or REPLAY: also restarts, with start winning over all other events.

Decomposition:
- Shared package holds:
  - move code constants MOVE_UP/RIGHT/LEFT/DOWN;
  - tracker state encoding IDLE/CAPTURE/REPLAY/DONE/ERROR;
  - err_code constants.
- Sub-module move_fifo:
  - parameterised synchronous FIFO, width 2, depth DEPTH;
  - ports: push, pop, clear, din, dout, full, empty, count;
  - pointers wrap modulo DEPTH.
- The top level holds the FSM and the position arithmetic.

Test Plan:
- start, capture 01,01,11,11,10 then path_done, hold step_ready=1 -> five consecutive step_valid cycles, moves replayed in order, final pos=(1,2), path_len=5, tracker_done=1.
- Same path with step_ready toggling 1-0-1-0 -> each step_move held stable while unaccepted, final pos=(1,2), no extra pops.
- start, capture 00 then path_done, replay -> y would go below 0: pos stays (0,0), error=1, err_code=11.
- DEPTH=4, push 5 moves -> 5th dropped, error=1, err_code=10, path_len=4.
- path_fail and path_done asserted together in CAPTURE -> err_code=01, REPLAY never entered.
- rst pulsed mid-REPLAY after 2 of 5 steps -> all outputs at reset values; a following start gives a clean capture with path_len=0.

Source files
------------

// File: rtl/maze_path_tracker_pkg.sv
// Shared types for the maze path tracker: move codes, tracker states and error codes.
package maze_path_tracker_pkg;

    typedef enum logic [1:0] {
        MOVE_UP    = 2'b00,
        MOVE_RIGHT = 2'b01,
        MOVE_LEFT  = 2'b10,
        MOVE_DOWN  = 2'b11
    } move_t;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        REPLAY,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_FAIL     = 2'b01,
        ERR_OVERFLOW = 2'b10,
        ERR_BOUNDS   = 2'b11
    } err_t;

endpackage

// File: rtl/maze_path_tracker_if.sv
// Solver-side move stream and consumer-side step handshake of the path tracker.
interface maze_path_tracker_if;
    logic       move_valid;
    logic [1:0] move;
    logic       path_done;
    logic       path_fail;
    logic       step_valid;
    logic       step_ready;
    logic [1:0] step_move;

    // master is the environment (solver + consumer), slave is the tracker
    modport master (
        output move_valid, move, path_done, path_fail, step_ready,
        input  step_valid, step_move
    );

    modport slave (
        input  move_valid, move, path_done, path_fail, step_ready,
        output step_valid, step_move
    );
endinterface

// File: rtl/maze_path_tracker_move_fifo.sv
// Synchronous move FIFO with combinational head read; pointers wrap modulo DEPTH.
module move_fifo
    import maze_path_tracker_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  move_t                  din,
    output move_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    move_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // NOTE: storage is deliberately not reset; empty/valid gating keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/maze_path_tracker.sv
// Captures a solver move stream, replays it under valid/ready and tracks the X/Y position.
module maze_path_tracker
    import maze_path_tracker_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_X  = 4,
    parameter int ADDR_Y  = 4,
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    maze_path_tracker_if.slave     bus,
    output logic [ADDR_X-1:0]      pos_x,
    output logic [ADDR_Y-1:0]      pos_y,
    output logic [$clog2(DEPTH):0] path_len,
    output logic                   busy,
    output logic                   tracker_done,
    output logic                   error,
    output logic [1:0]             err_code
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_X-1:0] X_START = ADDR_X'(START_X);
    localparam logic [ADDR_Y-1:0] Y_START = ADDR_Y'(START_Y);
    localparam logic [ADDR_X-1:0] X_MAX   = '1;
    localparam logic [ADDR_Y-1:0] Y_MAX   = '1;

    state_t            state_q, state_d;
    err_t              err_q, err_d;
    logic [ADDR_X-1:0] pos_x_q, pos_x_d, step_x;
    logic [ADDR_Y-1:0] pos_y_q, pos_y_d, step_y;
    logic [LW-1:0]     len_q, len_d;
    logic              step_oob;
    logic              step_valid;
    logic              step_fire;

    logic              fifo_push, fifo_pop, fifo_clear;
    logic              fifo_full, fifo_empty;
    logic [LW-1:0]     fifo_count;
    move_t             fifo_dout;

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .din   (move_t'(bus.move)),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign step_valid     = (state_q == REPLAY) && !fifo_empty;
    assign step_fire      = step_valid && bus.step_ready;
    assign bus.step_valid = step_valid;
    assign bus.step_move  = step_valid ? fifo_dout : MOVE_UP;

    // Candidate position for the head move; edges of the grid saturate into an error.
    always_comb begin
        step_x   = pos_x_q;
        step_y   = pos_y_q;
        step_oob = 1'b0;
        unique case (fifo_dout)
            MOVE_UP:    if (pos_y_q == '0)    step_oob = 1'b1; else step_y = pos_y_q - 1'b1;
            MOVE_RIGHT: if (pos_x_q == X_MAX) step_oob = 1'b1; else step_x = pos_x_q + 1'b1;
            MOVE_LEFT:  if (pos_x_q == '0)    step_oob = 1'b1; else step_x = pos_x_q - 1'b1;
            MOVE_DOWN:  if (pos_y_q == Y_MAX) step_oob = 1'b1; else step_y = pos_y_q + 1'b1;
            default:    ;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        len_d      = len_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;

        if (start) begin
            state_d    = CAPTURE;
            err_d      = ERR_NONE;
            pos_x_d    = X_START;
            pos_y_d    = Y_START;
            len_d      = '0;
            fifo_clear = 1'b1;
        end else begin
            unique case (state_q)
                CAPTURE: begin
                    if (bus.path_fail) begin
                        state_d = ERROR;
                        err_d   = ERR_FAIL;
                    end else if (bus.move_valid && fifo_full) begin
                        state_d = ERROR;
                        err_d   = ERR_OVERFLOW;
                    end else begin
                        if (bus.move_valid) begin
                            fifo_push = 1'b1;
                            len_d     = len_q + 1'b1;
                        end
                        if (bus.path_done) begin
                            state_d = (fifo_empty && !bus.move_valid) ? DONE : REPLAY;
                        end
                    end
                end
                REPLAY: begin
                    if (step_fire) begin
                        fifo_pop = 1'b1;
                        if (step_oob) begin
                            state_d = ERROR;
                            err_d   = ERR_BOUNDS;
                        end else begin
                            pos_x_d = step_x;
                            pos_y_d = step_y;
                            if (fifo_count == LW'(1)) state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= ERR_NONE;
            pos_x_q <= X_START;
            pos_y_q <= Y_START;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            len_q   <= len_d;
        end
    end

    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign path_len     = len_q;
    assign busy         = (state_q == CAPTURE) || (state_q == REPLAY);
    assign tracker_done = (state_q == DONE);
    assign error        = (state_q == ERROR);
    assign err_code     = err_q;

endmodule

// File: tb/tb_maze_path_tracker.sv
// Directed and randomized bench for maze_path_tracker against a path-walking reference model.
module tb_maze_path_tracker;
    import maze_path_tracker_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start_s;
    always #5 clk = ~clk;

    maze_path_tracker_if bus();
    maze_path_tracker_if bus_s();

    logic [3:0] pos_x, pos_y;
    logic [8:0] path_len;
    logic       busy, tracker_done, error;
    logic [1:0] err_code;

    logic [3:0] s_pos_x, s_pos_y;
    logic [2:0] s_path_len;
    logic       s_busy, s_tracker_done, s_error;
    logic [1:0] s_err_code;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] path_q[$];

    maze_path_tracker #(.DEPTH(256), .ADDR_X(4), .ADDR_Y(4), .START_X(0), .START_Y(0)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .pos_x(pos_x), .pos_y(pos_y), .path_len(path_len), .busy(busy),
        .tracker_done(tracker_done), .error(error), .err_code(err_code)
    );

    maze_path_tracker #(.DEPTH(4), .ADDR_X(4), .ADDR_Y(4), .START_X(0), .START_Y(0)) dut_small (
        .clk(clk), .rst(rst), .start(start_s), .bus(bus_s),
        .pos_x(s_pos_x), .pos_y(s_pos_y), .path_len(s_path_len), .busy(s_busy),
        .tracker_done(s_tracker_done), .error(s_error), .err_code(s_err_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the path on an unbounded integer grid; the first step leaving 0..15 is the fault.
    task automatic model(output int ex, output int ey, output int acc, output int ec);
        int nx, ny;
        ex = 0; ey = 0; ec = 0;
        acc = path_q.size();
        for (int i = 0; i < path_q.size(); i++) begin
            nx = ex; ny = ey;
            case (path_q[i])
                2'd0: ny = ny - 1;
                2'd1: nx = nx + 1;
                2'd2: nx = nx - 1;
                default: ny = ny + 1;
            endcase
            if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
                acc = i + 1;
                ec  = 3;
                break;
            end
            ex = nx; ey = ny;
        end
    endtask

    task automatic load(input logic [31:0] codes, input int n);
        path_q.delete();
        for (int i = 0; i < n; i++) path_q.push_back(codes[2*i +: 2]);
    endtask

    task automatic check_reset_state(input string p);
        check({p, ".pos_x"}, pos_x, 0);
        check({p, ".pos_y"}, pos_y, 0);
        check({p, ".path_len"}, path_len, 0);
        check({p, ".busy"}, busy, 0);
        check({p, ".done"}, tracker_done, 0);
        check({p, ".error"}, error, 0);
        check({p, ".err_code"}, err_code, 0);
        check({p, ".step_valid"}, bus.step_valid, 0);
        check({p, ".step_move"}, bus.step_move, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start.busy", busy, 1);
        check("start.path_len", path_len, 0);
        check("start.pos", {pos_x, pos_y}, 0);
        check("start.error", error, 0);
    endtask

    task automatic capture(input bit done_last);
        for (int i = 0; i < path_q.size(); i++) begin
            bus.move_valid = 1'b1;
            bus.move       = path_q[i];
            bus.path_done  = done_last && (i == path_q.size() - 1);
            tick();
        end
        bus.move_valid = 1'b0;
        if (!(done_last && path_q.size() > 0)) begin
            bus.path_done = 1'b1;
            tick();
        end
        bus.path_done = 1'b0;
        bus.move      = 2'd0;
    endtask

    // mode 0: always ready, 1: ready toggles 1-0-1-0, 2: random ready
    task automatic replay(input int mode, input int n_exp, input int stop_after);
        int idx = 0;
        int cyc = 0;
        int vcyc = 0;
        bit rdy;
        while (busy && cyc < 4 * n_exp + 20) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.step_ready = rdy;
            if (bus.step_valid) begin
                vcyc++;
                check("step_in_range", 32'(idx < n_exp), 1);
                if (idx < n_exp) check($sformatf("step_move[%0d]", idx), bus.step_move, path_q[idx]);
                if (rdy) idx++;
            end
            tick();
            cyc++;
            if (stop_after > 0 && idx == stop_after) break;
        end
        bus.step_ready = 1'b0;
        if (stop_after <= 0) begin
            check("replay_timeout", busy, 0);
            check("accepted_steps", idx, n_exp);
            if (mode == 0) check("valid_cycles", vcyc, n_exp);
        end
    endtask

    task automatic run_path(input string name, input int mode, input bit done_last);
        int ex, ey, acc, ec;
        model(ex, ey, acc, ec);
        pulse_start();
        capture(done_last);
        check({name, ".path_len"}, path_len, path_q.size());
        replay(mode, acc, 0);
        tick();
        check({name, ".pos_x"}, pos_x, ex);
        check({name, ".pos_y"}, pos_y, ey);
        check({name, ".err_code"}, err_code, ec);
        check({name, ".error"}, error, 32'(ec != 0));
        check({name, ".done"}, tracker_done, 32'(ec == 0));
        check({name, ".step_valid"}, bus.step_valid, 0);
        check({name, ".path_len_hold"}, path_len, path_q.size());
    endtask

    initial begin
        #2_000_000;
        $fatal(1, "FAIL watchdog: simulation did not finish in time");
    end

    initial begin
        int len, r, mode;
        rst = 1'b1; start = 1'b0; start_s = 1'b0;
        bus.move_valid = 1'b0; bus.move = 2'd0; bus.path_done = 1'b0;
        bus.path_fail = 1'b0; bus.step_ready = 1'b0;
        bus_s.move_valid = 1'b0; bus_s.move = 2'd0; bus_s.path_done = 1'b0;
        bus_s.path_fail = 1'b0; bus_s.step_ready = 1'b0;
        tick(); tick();
        check_reset_state("reset");
        rst = 1'b0;

        // IDLE ignores everything except start
        bus.move_valid = 1'b1; bus.path_done = 1'b1; bus.step_ready = 1'b1;
        tick(); tick();
        bus.move_valid = 1'b0; bus.path_done = 1'b0; bus.step_ready = 1'b0;
        check_reset_state("idle");

        // 01,01,11,11,10 -> (1,2): streaming, then with toggling ready
        load({2'b10, 2'b11, 2'b11, 2'b01, 2'b01}, 5);
        run_path("path5_ready", 0, 1'b0);
        run_path("path5_toggle", 1, 1'b0);
        check("path5.final", {pos_x, pos_y}, {4'd1, 4'd2});

        // single up from the origin leaves the grid
        load(32'b00, 1);
        run_path("oob_up", 0, 1'b0);
        tick(); tick();
        check("oob_up.hold_pos", {pos_x, pos_y}, 0);
        check("oob_up.hold_err", err_code, 3);

        // 16 rights: the last one crosses x=15
        load(32'h5555_5555, 16);
        run_path("oob_right", 2, 1'b1);

        // empty path goes straight to DONE
        path_q.delete();
        run_path("empty", 0, 1'b0);

        // fail and done together: fail wins, replay never entered
        pulse_start();
        bus.move_valid = 1'b1; bus.move = 2'd1;
        tick();
        bus.move_valid = 1'b0;
        bus.path_fail = 1'b1; bus.path_done = 1'b1;
        tick();
        bus.path_fail = 1'b0; bus.path_done = 1'b0;
        check("fail.error", error, 1);
        check("fail.err_code", err_code, 1);
        check("fail.step_valid", bus.step_valid, 0);
        tick();
        check("fail.busy", busy, 0);
        check("fail.done", tracker_done, 0);

        // start during CAPTURE restarts and beats a simultaneous move
        pulse_start();
        load({2'b11, 2'b01, 2'b11}, 3);
        capture(1'b0);
        bus.move_valid = 1'b1;
        pulse_start();
        bus.move_valid = 1'b0;
        load({2'b11, 2'b01}, 2);
        capture(1'b0);
        check("restart.path_len", path_len, 2);
        replay(0, 2, 0);
        check("restart.pos", {pos_x, pos_y}, {4'd1, 4'd1});

        // async reset in the middle of REPLAY
        load({2'b10, 2'b11, 2'b11, 2'b01, 2'b01}, 5);
        pulse_start();
        capture(1'b0);
        replay(0, 5, 2);
        check("midrst.pos_before", {pos_x, pos_y}, {4'd2, 4'd0});
        #2 rst = 1'b1;
        #1;
        check_reset_state("midrst");
        tick();
        rst = 1'b0;
        load({2'b01, 2'b11}, 2);
        run_path("after_rst", 0, 1'b0);

        // randomized paths, biased down/right so some stay in the grid for a while
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(0, 40);
            path_q.delete();
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                path_q.push_back(r == 0 ? 2'd0 : r == 1 ? 2'd2 : r < 6 ? 2'd1 : 2'd3);
            end
            mode = $urandom_range(0, 2);
            run_path($sformatf("rand%0d", t), mode, 1'($urandom_range(0, 1)));
        end

        // DEPTH=4 instance: fifth move overflows
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_s.move_valid = 1'b1;
            bus_s.move       = 2'd1;
            tick();
            if (i == 3) begin
                check("ovf.len4", s_path_len, 4);
                check("ovf.no_err_yet", s_error, 0);
            end
        end
        bus_s.move_valid = 1'b0;
        check("ovf.error", s_error, 1);
        check("ovf.err_code", s_err_code, 2);
        check("ovf.path_len", s_path_len, 4);
        check("ovf.busy", s_busy, 0);
        check("ovf.step_valid", bus_s.step_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
